// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues in-order word reads and buffers
// returned words in a small FIFO presented to decode with a pre-decoded imm_src.
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [1:0]  imm_src
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;

    logic [31:0] data_q [DEPTH];
    logic [31:0] pc_q   [DEPTH];
    // PC of each in-flight request, consumed in order as responses return
    logic [31:0] tag_q  [DEPTH];

    logic req_hs, push, pop;

    // Credit rule: buffered words plus in-flight requests never exceed the FIFO depth
    always_comb begin
        imem_req_valid = !reset && !redirect_valid &&
                         (({1'b0, count_q} + {1'b0, outstanding_q}) < DEPTH_W);
        imem_req_addr  = fetch_pc_q;
        req_hs         = imem_req_valid && imem_req_ready;
        push           = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
        pop            = instr_valid && instr_ready && !redirect_valid;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        tag_rd_d      = tag_rd_q;
        tag_wr_d      = tag_wr_q;
        count_d       = count_q;
        drop_d        = drop_q;
        outstanding_d = outstanding_q + CW'(req_hs) - CW'(imem_rsp_valid);

        if (req_hs) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            tag_wr_d   = tag_wr_q + 1'b1;
        end
        if (imem_rsp_valid) begin
            tag_rd_d = tag_rd_q + 1'b1;
        end

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
            count_d    = '0;
            rd_ptr_d   = wr_ptr_q;
            drop_d     = outstanding_q - CW'(imem_rsp_valid);
        end else begin
            if (imem_rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - 1'b1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            tag_rd_q      <= '0;
            tag_wr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            tag_rd_q      <= tag_rd_d;
            tag_wr_q      <= tag_wr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            assert (!(push && !pop && (count_q == DEPTH_C)));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && req_hs) begin
            tag_q[tag_wr_q] <= fetch_pc_q;
        end
        if (!reset && push) begin
            data_q[wr_ptr_q] <= imem_rsp_data;
            pc_q[wr_ptr_q]   <= tag_q[tag_rd_q];
        end
    end

    always_comb begin
        instr_valid = (count_q != '0);
        instr       = instr_valid ? data_q[rd_ptr_q] : 32'h0;
        instr_pc    = instr_valid ? pc_q[rd_ptr_q] : 32'h0;
        unique case (instr[6:0])
            7'b0100011: imm_src = 2'd1;
            7'b1100011: imm_src = 2'd2;
            7'b1101111: imm_src = 2'd3;
            default:    imm_src = 2'd0;
        endcase
    end

endmodule
